// File: rtl/axistream_snooper.sv
// AXI Stream slave that copies one packet at a time into a packet memory buffer,
// truncating packets longer than the buffer and reporting length on completion.
module axistream_snooper #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] TDATA,
    input  logic                  TVALID,
    input  logic                  TLAST,
    output logic                  TREADY,
    output logic [ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [DATA_WIDTH-1:0] snooper_wr_data,
    output logic                  snooper_wr_en,
    output logic                  snooper_done,
    output logic [ADDR_WIDTH:0]   len_from_snooper,
    output logic                  snooper_truncated,
    input  logic                  ready_for_snooper,
    output logic [2:0]            o_dbg_state
);

    // Handshake: a beat happens in any cycle where TVALID and TREADY are both
    // high at the rising edge; TDATA/TLAST are only looked at on beats.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_DROP  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_COUNT = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_trunc;
    logic                  w_tready;
    logic                  w_beat;
    logic [ADDR_WIDTH:0]   w_count_inc;
    logic                  w_fills_buffer;

    // Once a packet has started the buffer is ours, so ready_for_snooper only
    // matters while idle.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            S_IDLE:  w_tready = ready_for_snooper;
            S_RECV:  w_tready = 1'b1;
            S_DROP:  w_tready = 1'b1;
            default: w_tready = 1'b0;
        endcase
    end

    assign TREADY         = w_tready;
    assign w_beat         = TVALID && w_tready;
    assign w_count_inc    = r_count + ONE_COUNT;
    assign w_fills_buffer = (w_count_inc == MAX_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_next = TLAST ? S_FLUSH : S_RECV;
                end
            end
            S_RECV: begin
                if (w_beat) begin
                    if (TLAST) begin
                        w_next = S_FLUSH;
                    end else if (w_fills_buffer) begin
                        w_next = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (w_beat && TLAST) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count         <= '0;
            r_trunc         <= 1'b0;
            snooper_wr_en   <= 1'b0;
            snooper_wr_addr <= '0;
            snooper_wr_data <= '0;
        end else begin
            snooper_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        snooper_wr_en   <= 1'b1;
                        snooper_wr_addr <= '0;
                        snooper_wr_data <= TDATA;
                        r_count         <= ONE_COUNT;
                        r_trunc         <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (w_beat) begin
                        snooper_wr_en   <= 1'b1;
                        snooper_wr_addr <= r_count[ADDR_WIDTH-1:0];
                        snooper_wr_data <= TDATA;
                        r_count         <= w_count_inc;
                        // Filling the buffer without TLAST means more flits follow.
                        if (!TLAST && w_fills_buffer) begin
                            r_trunc <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_count <= '0;
                    r_trunc <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign snooper_done      = (r_state == S_DONE);
    assign len_from_snooper  = snooper_done ? r_count : '0;
    assign snooper_truncated = snooper_done && r_trunc;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_axistream_snooper.sv
// Directed bench for axistream_snooper with an 8-flit buffer.
module tb_axistream_snooper;

    localparam int DW = 64;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          done;
    logic [AW:0]   len;
    logic          trunc;
    logic          ready;
    logic [2:0]    dbg_state;

    int checks      = 0;
    int failures    = 0;
    int done_cnt    = 0;
    int double_done = 0;
    int base;
    logic prev_done = 1'b0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_e;

    axistream_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .TDATA             (tdata),
        .TVALID            (tvalid),
        .TLAST             (tlast),
        .TREADY            (tready),
        .snooper_wr_addr   (wr_addr),
        .snooper_wr_data   (wr_data),
        .snooper_wr_en     (wr_en),
        .snooper_done      (done),
        .len_from_snooper  (len),
        .snooper_truncated (trunc),
        .ready_for_snooper (ready),
        .o_dbg_state       (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (prev_done) double_done++;
        end
        prev_done = done;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(exp_e[AW+DW-1:DW]));
                chk("wr_data", wr_data, exp_e[DW-1:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; ready = 1'b1;
        repeat (2) tick();
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        chk("rst_trunc", 64'(trunc), 64'd0);
        chk("rst_tready", 64'(tready), 64'd1);
        chk("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        tick();

        // 3-flit packet, continuous valid
        tvalid = 1'b1; tdata = 64'hA; tlast = 1'b0; expect_write(3'd0, 64'hA);
        tick(); chk("a_wr_en0", 64'(wr_en), 64'd1);
        tdata = 64'hB; expect_write(3'd1, 64'hB);
        tick(); chk("a_wr_en1", 64'(wr_en), 64'd1);
        tdata = 64'hC; tlast = 1'b1; expect_write(3'd2, 64'hC);
        tick(); chk("a_wr_en2", 64'(wr_en), 64'd1);
        chk("a_tready_flush", 64'(tready), 64'd0);
        chk("a_done_early", 64'(done), 64'd0);
        chk("a_len_early", 64'(len), 64'd0);
        tvalid = 1'b0; tlast = 1'b0;
        tick();
        chk("a_done", 64'(done), 64'd1);
        chk("a_len", 64'(len), 64'd3);
        chk("a_trunc", 64'(trunc), 64'd0);
        chk("a_wr_en_done", 64'(wr_en), 64'd0);
        tick();
        chk("a_done_off", 64'(done), 64'd0);
        chk("a_len_off", 64'(len), 64'd0);
        chk("a_tready_idle", 64'(tready), 64'd1);

        // Packet memory not ready: valid held off
        ready = 1'b0; tvalid = 1'b1; tdata = 64'h1111; tlast = 1'b0;
        #1 chk("b_tready_low", 64'(tready), 64'd0);
        tick(); chk("b_no_write0", 64'(wr_en), 64'd0);
        tick(); chk("b_no_write1", 64'(wr_en), 64'd0);
        ready = 1'b1;
        #1 chk("b_tready_high", 64'(tready), 64'd1);
        expect_write(3'd0, 64'h1111);
        tick(); chk("b_wr_en0", 64'(wr_en), 64'd1);
        tdata = 64'h2222; tlast = 1'b1; expect_write(3'd1, 64'h2222);
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        tick();
        chk("b_done", 64'(done), 64'd1);
        chk("b_len", 64'(len), 64'd2);
        tick();

        // 11-flit packet into an 8-flit buffer
        for (int i = 0; i < 11; i++) begin
            tvalid = 1'b1; tdata = 64'h100 + 64'(i); tlast = (i == 10);
            if (i < 8) expect_write(AW'(i), 64'h100 + 64'(i));
            tick();
            chk($sformatf("c_wr_en%0d", i), 64'(wr_en), (i < 8) ? 64'd1 : 64'd0);
            if (i == 8) begin
                chk("c_drop_state", 64'(dbg_state), 64'd2);
                chk("c_drop_tready", 64'(tready), 64'd1);
                chk("c_drop_trunc_hidden", 64'(trunc), 64'd0);
            end
        end
        chk("c_tready_flush", 64'(tready), 64'd0);
        tvalid = 1'b0; tlast = 1'b0;
        tick();
        chk("c_done", 64'(done), 64'd1);
        chk("c_len", 64'(len), 64'd8);
        chk("c_trunc", 64'(trunc), 64'd1);
        tick();
        chk("c_trunc_off", 64'(trunc), 64'd0);
        chk("c_done_off", 64'(done), 64'd0);

        // Single-flit packet, valid kept high through FLUSH/DONE
        tvalid = 1'b1; tdata = 64'h55; tlast = 1'b1; expect_write(3'd0, 64'h55);
        tick();
        chk("d_wr_en", 64'(wr_en), 64'd1);
        chk("d_tready_flush", 64'(tready), 64'd0);
        tdata = 64'h99; tlast = 1'b0;
        tick();
        chk("d_tready_done", 64'(tready), 64'd0);
        chk("d_done", 64'(done), 64'd1);
        chk("d_len", 64'(len), 64'd1);
        chk("d_no_write", 64'(wr_en), 64'd0);
        tvalid = 1'b0;
        tick();
        chk("d_done_off", 64'(done), 64'd0);
        chk("d_tready_idle", 64'(tready), 64'd1);

        // Valid toggling, garbage on idle cycles, ready dropped mid-packet
        base = done_cnt;
        for (int i = 0; i < 4; i++) begin
            tvalid = 1'b1; tdata = 64'h200 + 64'(i); tlast = (i == 3);
            expect_write(AW'(i), 64'h200 + 64'(i));
            tick();
            chk($sformatf("e_wr_en%0d", i), 64'(wr_en), 64'd1);
            tvalid = 1'b0; tdata = 64'hDEAD; tlast = 1'b1;
            if (i == 0) ready = 1'b0;
            tick();
            if (i < 3) begin
                chk($sformatf("e_gap%0d", i), 64'(wr_en), 64'd0);
                chk($sformatf("e_tready%0d", i), 64'(tready), 64'd1);
            end
        end
        chk("e_done", 64'(done), 64'd1);
        chk("e_len", 64'(len), 64'd4);
        ready = 1'b1; tlast = 1'b0;
        tick();
        chk("e_done_once", 64'(done_cnt - base), 64'd1);

        // Reset in the middle of a packet
        base = done_cnt;
        tvalid = 1'b1; tdata = 64'h1; tlast = 1'b0; expect_write(3'd0, 64'h1);
        tick(); chk("f_wr_en0", 64'(wr_en), 64'd1);
        tdata = 64'h2;
        tick(); chk("f_wr_en1", 64'(wr_en), 64'd1);
        rst_n = 1'b0; tvalid = 1'b0;
        #1;
        chk("f_rst_wr_en", 64'(wr_en), 64'd0);
        chk("f_rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("f_rst_wr_data", wr_data, 64'd0);
        chk("f_rst_done", 64'(done), 64'd0);
        chk("f_rst_len", 64'(len), 64'd0);
        chk("f_rst_state", 64'(dbg_state), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        tvalid = 1'b1; tdata = 64'h31; expect_write(3'd0, 64'h31);
        tick();
        tdata = 64'h32; tlast = 1'b1; expect_write(3'd1, 64'h32);
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        tick();
        chk("f_done", 64'(done), 64'd1);
        chk("f_len", 64'(len), 64'd2);
        tick();
        chk("f_done_once", 64'(done_cnt - base), 64'd1);

        chk("double_done", 64'(double_done), 64'd0);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axistream_snooper.md
AXISTREAM_SNOOPER -- requirements
Module: axistream_snooper

Interface
REQ-001 Parameter DATA_WIDTH, default 64, flit width in bits.
REQ-002 Parameter ADDR_WIDTH, default 9, packetmem word-address width; max packet = 2^ADDR_WIDTH flits.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 TDATA  input  DATA_WIDTH  AXI Stream slave data.
REQ-006 TVALID  input  1  slave valid.
REQ-007 TLAST  input  1  last flit of packet.
REQ-008 TREADY  output  1  slave ready, combinational from state and ready_for_snooper.
REQ-009 snooper_wr_addr  output  ADDR_WIDTH  packetmem write address, registered.
REQ-010 snooper_wr_data  output  DATA_WIDTH  packetmem write data, registered.
REQ-011 snooper_wr_en  output  1  packetmem write strobe, registered.
REQ-012 snooper_done  output  1  one-cycle pulse: packet complete in packetmem.
REQ-013 len_from_snooper  output  ADDR_WIDTH+1  packet length in flits, valid while snooper_done=1.
REQ-014 snooper_truncated  output  1  high with snooper_done when packet exceeded 2^ADDR_WIDTH flits.
REQ-015 ready_for_snooper  input  1  packetmem has a free buffer; may drop only in the cycle after snooper_done.

Function
REQ-016 Beat = TVALID && TREADY in a cycle; only beats change data-path state.
REQ-017 States: IDLE, RECV, DROP, FLUSH, DONE.
REQ-018 TREADY = ready_for_snooper in IDLE; 1 in RECV and DROP; 0 in FLUSH and DONE.
REQ-019 IDLE, beat: write TDATA at addr 0, count := 1; TLAST ? FLUSH : RECV.
REQ-020 RECV, beat: write at addr = count[ADDR_WIDTH-1:0], count := count+1.
REQ-021 RECV, beat with TLAST -> FLUSH.
REQ-022 RECV, beat without TLAST that brings count to 2^ADDR_WIDTH -> DROP.
REQ-023 DROP: accept and discard beats (no write), count frozen at 2^ADDR_WIDTH, truncation flag set; beat with TLAST -> FLUSH.
REQ-024 A write for a beat in cycle N appears as wr_en=1 with the matching wr_addr/wr_data in cycle N+1; otherwise wr_en=0 and wr_addr/wr_data hold.
REQ-025 FLUSH lasts one cycle (last write, if any, retires) -> DONE.
REQ-026 DONE lasts one cycle: snooper_done=1, len_from_snooper=count, snooper_truncated=flag; then IDLE, count and flag cleared.
REQ-027 Last beat in cycle N -> snooper_done in cycle N+2; earliest next-packet beat in N+3.
REQ-028 snooper_done SHALL never be high in two consecutive cycles.
REQ-029 Outside DONE, len_from_snooper and snooper_truncated SHALL be 0.
REQ-030 count is ADDR_WIDTH+1 bits, no wrap; wr_addr never exceeds 2^ADDR_WIDTH-1.
REQ-031 TVALID low mid-packet: state and count hold indefinitely, no timeout.
REQ-032 ready_for_snooper falling mid-packet: ignored until IDLE (buffer already owned).
REQ-033 TDATA/TLAST sampled only on beats; values with TVALID=0 have no effect.

Reset
REQ-034 rst_n low asynchronously forces IDLE, count=0, flag=0, wr_en=0, wr_addr=0, wr_data=0, snooper_done=0.
REQ-035 Reset mid-packet drops the partial packet silently; no snooper_done.
REQ-036 After rst_n rises, the first beat is treated as the first flit of a new packet.

Verification
REQ-037 ready=1, 3-flit packet A,B,C with TLAST on C, TVALID continuous -> writes (0,A),(1,B),(2,C) on consecutive cycles; done 2 cycles after C beat with len=3, truncated=0.
REQ-038 ready=0 with TVALID=1 -> TREADY=0, no write; ready=1 -> packet accepted from addr 0.
REQ-039 ADDR_WIDTH=3, 11-flit packet -> 8 writes to addrs 0..7, 3 beats discarded; done with len=8, truncated=1.
REQ-040 1-flit packet (TLAST on first beat) -> one write at 0, done with len=1; TREADY=0 for the 2 cycles after the beat.
REQ-041 TVALID toggled 1/0 through a 4-flit packet -> addrs 0..3 contiguous, len=4; done asserted exactly once.
REQ-042 rst_n pulsed low after 2 beats -> all outputs 0 immediately; no done; next 2-flit packet written at 0,1 with len=2.
